hilo_muldiv_unit: RTL

//  Iterative MIPS multiply/divide unit owning the HI/LO registers. Accepts

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 45 ++++
 rtl/hilo_muldiv_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states and
// the default iteration count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

  // One result bit per CALC cycle for a 32-bit datapath.
  localparam int unsigned IterCount = 32;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// trial-subtract divide step, selected by div_mode_i.
module muldiv_step #(
  parameter int unsigned Width = 32
) (
  input  logic             div_mode_i,
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  logic [Width:0] sum;
  logic [Width:0] shifted;
  logic           ge;

  always_comb begin
    sum     = {1'b0, rem_i} + {1'b0, b_i};
    shifted = {rem_i, quo_i[Width-1]};
    // A set top bit means the shifted remainder already exceeds any divisor.
    ge      = shifted[Width] || (shifted[Width-1:0] >= b_i);
    rem_o   = rem_i;
    quo_o   = quo_i;
    if (div_mode_i) begin
      if (ge) begin
        rem_o = shifted[Width-1:0] - b_i;
        quo_o = {quo_i[Width-2:0], 1'b1};
      end else begin
        rem_o = shifted[Width-1:0];
        quo_o = {quo_i[Width-2:0], 1'b0};
      end
    end else begin
      // {rem, quo} is the product accumulator; multiplier bits shift out of quo.
      if (quo_i[0]) begin
        rem_o = sum[Width:1];
        quo_o = {sum[0], quo_i[Width-1:1]};
      end else begin
        rem_o = {1'b0, rem_i[Width-1:1]};
        quo_o = {rem_i[0], quo_i[Width-1:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO. Magnitudes are processed one
// bit per cycle, then signs are applied in a single fix-up cycle.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned data_bits = IterCount - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [data_bits:0] rs_val,
  input  logic [data_bits:0] rt_val,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [data_bits:0] hi,
  output logic [data_bits:0] lo
);

  localparam int unsigned W     = data_bits + 1;
  localparam int unsigned Iters = data_bits + 1;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    rem_q, quo_q, b_q, a_raw_q;
  logic            is_div_q, neg_q_q, neg_r_q;
  logic            busy_q, done_q;
  logic [W-1:0]    hi_q, lo_q;

  logic [W-1:0]    rem_d, quo_d;
  logic            signed_op;
  logic [W-1:0]    a_mag, b_mag;
  logic [2*W-1:0]  prod, prod_fix;
  logic [W-1:0]    quo_fix, rem_fix, fix_hi, fix_lo;

  muldiv_step #(
    .Width (W)
  ) u_step (
    .div_mode_i (is_div_q),
    .rem_i      (rem_q),
    .quo_i      (quo_q),
    .b_i        (b_q),
    .rem_o      (rem_d),
    .quo_o      (quo_d)
  );

  always_comb begin
    signed_op = op_is_signed(op);
    a_mag     = (signed_op && rs_val[data_bits]) ? -rs_val : rs_val;
    b_mag     = (signed_op && rt_val[data_bits]) ? -rt_val : rt_val;
    prod      = {rem_q, quo_q};
    prod_fix  = neg_q_q ? -prod : prod;
    quo_fix   = neg_q_q ? -quo_q : quo_q;
    rem_fix   = neg_r_q ? -rem_q : rem_q;
    if (is_div_q) begin
      // Divide by zero returns the raw dividend in HI and all ones in LO.
      if (b_q == '0) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end else begin
      fix_hi = prod_fix[2*W-1:W];
      fix_lo = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            case (op)
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q  <= StCalc;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                rem_q    <= '0;
                quo_q    <= a_mag;
                b_q      <= b_mag;
                a_raw_q  <= rs_val;
                is_div_q <= (op == OP_DIV) || (op == OP_DIVU);
                neg_q_q  <= signed_op && (rs_val[data_bits] ^ rt_val[data_bits]);
                neg_r_q  <= signed_op && rs_val[data_bits];
              end
              default: ;
            endcase
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntW'(Iters)) begin
            // All bits done; one settle cycle before the sign fix-up.
            state_q <= StFix;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFix: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
